// File: rtl/pts_sr_8_tx.sv
// pts_sr_8_tx: parallel-to-serial transmitter for NUM_WORDS-word blocks.
// Captures a whole block (e.g. a SHA-256 digest) in one cycle.
// It then streams the block out one word at a time on a valid/ready handshake.
// A new block can be loaded in the same cycle that the last word of the
// previous block is accepted, so back-to-back blocks have no bubble.
// Optional feature macro: PTS_SR_ABORT_EN adds an 'abort' input that drops
// the block in flight and returns to IDLE without a done pulse.
module pts_sr_8_tx #(
  parameter int NUM_WORDS = 8,
  parameter int WORD_W    = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          load,
  input  logic [NUM_WORDS*WORD_W-1:0]   parallel_in,
  output logic                          load_ready,
  output logic [WORD_W-1:0]             serial_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic [3:0]                    word_idx,
`ifdef PTS_SR_ABORT_EN
  input  logic                          abort,
`endif
  output logic                          done
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_SEND   = 1'b1;
  localparam logic [3:0] LAST_IDX = 4'(NUM_WORDS - 1);

  logic [0:0]                  r_state;
  logic [NUM_WORDS*WORD_W-1:0] r_buf;
  logic [3:0]                  r_idx;
  logic                        r_done;

  logic                        w_send;
  logic                        w_xfer;
  logic                        w_last;
  logic                        w_abort;
  logic                        w_capture;
  logic [WORD_W-1:0]           w_word;

  // Word k of the block in transmit order; MSB_FIRST picks which end goes first.
  function automatic logic [WORD_W-1:0] sel_word(
    input logic [NUM_WORDS*WORD_W-1:0] blk,
    input logic [3:0]                  idx
  );
    int pos;
    pos = MSB_FIRST ? (NUM_WORDS - 1 - int'(idx)) : int'(idx);
    return blk[pos*WORD_W +: WORD_W];
  endfunction

`ifdef PTS_SR_ABORT_EN
  assign w_abort = w_send & abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_send = (r_state == S_SEND);
  assign w_xfer = w_send & out_ready;
  assign w_last = w_send & (r_idx == LAST_IDX);

  // Loadable when idle, or when the final word leaves this cycle (no bubble).
  // An abort in the same cycle takes priority, so the load is refused.
  assign load_ready = (r_state == S_IDLE) | (w_xfer & w_last & ~w_abort);
  assign w_capture  = load & load_ready;

  // Outputs come only from registers; serial_out is forced to zero when idle
  // so stale buffer contents never appear on the bus.
  assign w_word     = sel_word(r_buf, r_idx);
  assign serial_out = w_send ? w_word : '0;
  assign out_valid  = w_send;
  assign out_last   = w_last;
  assign word_idx   = r_idx;
  assign done       = r_done;

  // Control FSM: state, word index and the one-cycle done pulse.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
      r_idx   <= 4'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_capture) begin
          r_state <= S_SEND;
          r_idx   <= 4'd0;
        end
      end else if (w_abort) begin
        r_state <= S_IDLE;
        r_idx   <= 4'd0;
      end else if (w_xfer) begin
        if (w_last) begin
          r_done <= 1'b1;
          r_idx  <= 4'd0;
          if (!load) begin
            r_state <= S_IDLE;
          end
        end else begin
          r_idx <= r_idx + 4'd1;
        end
      end
    end
  end

  // Block buffer: written only on an accepted load, otherwise held.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_buf <= '0;
    end else if (w_capture) begin
      r_buf <= parallel_in;
    end
  end

endmodule

// File: doc/pts_sr_8_tx.md
Name: pts_sr_8_tx

Overview:
- Parallel-to-serial transmitter for 8-word (256-bit) blocks; the counterpart of the 8-word serial-to-parallel shift register.
- Captures a 256-bit block, such as a finished SHA-256 digest, in one cycle.
- Emits the block as a stream of 32-bit words using a valid/ready handshake.
- Sits between the hash core output and the word-wide host/output interface.

Parameters:
- NUM_WORDS, 8, number of words per block; legal range 2..16.
- WORD_W, 32, width of each word in bits.
- MSB_FIRST, 1, 1 = first word out is parallel_in[255:224]; 0 = first word out is parallel_in[31:0].

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- n_rst  input  1  asynchronous active-low reset.
- load  input  1  request to capture parallel_in.
- parallel_in  input  NUM_WORDS*WORD_W  block to transmit.
- load_ready  output  1  transmitter can accept a load this cycle.
- serial_out  output  WORD_W  current word.
- out_valid  output  1  serial_out holds a valid word.
- out_ready  input  1  downstream accepts the word this cycle.
- out_last  output  1  current word is the final word of the block.
- word_idx  output  4  index of the current word, 0..NUM_WORDS-1.
- done  output  1  one-cycle pulse after the final word is accepted.

Behaviour:
- Reset (n_rst low, asynchronous):
  - state=IDLE, internal buffer=0, word_idx=0.
  - out_valid=0, out_last=0, done=0, serial_out=0, load_ready=1 once reset is released.
- States: IDLE, SEND.
- Word accepted ("xfer"): out_valid & out_ready in the same cycle.
- load_ready (combinational):
  - 1 in IDLE.
  - 1 in SEND when xfer & out_last in that cycle, allowing back-to-back blocks.
  - 0 otherwise.
- IDLE:
  - out_valid=0, serial_out=0.
  - load & load_ready: capture parallel_in into the buffer, set word_idx=0, go to SEND.
  - The first word is valid on the cycle after the load. Load-to-first-word latency is 1 clock.
- SEND:
  - out_valid=1.
  - serial_out = buffer word selected by word_idx and MSB_FIRST, driven straight from registers with no combinational path from inputs.
  - out_last = (word_idx == NUM_WORDS-1).
- out_ready low in SEND: serial_out, word_idx and out_last hold; the word is never dropped or repeated.
- xfer and not last: word_idx increments by 1.
- xfer and last:
  - done=1 on the next cycle only.
  - If load is asserted in the same cycle: capture the new block, word_idx=0, stay in SEND. No bubble: the next cycle shows word 0 of the new block.
  - Otherwise go to IDLE and set word_idx=0.
- load in SEND when load_ready=0: ignored; the buffer is unchanged.
- load and reset together: reset wins.
- Reset asserted mid-block: the block is discarded, all outputs return to reset values, and no done pulse is produced.
- Throughput: one word per clock while out_ready=1. An 8-word block occupies exactly 8 SEND cycles.

Optional Feature:
- Macro: PTS_SR_ABORT_EN.
- When defined:
  - Adds input port abort (1 bit).
  - abort=1 in SEND forces IDLE on the next edge with word_idx=0 and out_valid=0.
  - No done pulse is produced, and the buffer contents are don't-care.
  - abort has priority over xfer and load in the same cycle.
  - abort in IDLE has no effect.
- When undefined: the abort port does not exist and the block behaves exactly as described above.

Test Plan:
- Reset, then load with parallel_in = {32'h8,32'h7,...,32'h1} (MSB word = 8) and out_ready held 1 -> serial_out = 8,7,6,5,4,3,2,1 on 8 consecutive cycles starting 1 cycle after load; out_last only on the word 1; done pulses once on the following cycle.
- Same load with out_ready toggling 1,0,0,1,... -> each word holds steady while out_ready=0; the sequence still reads 8..1 with no drop or duplicate; exactly 8 xfers.
- Back-to-back blocks: assert load with block B = {32'hB0..32'hB7} in the cycle the last word of block A is accepted -> load_ready=1 in that cycle; B's first word 32'hB0 follows A's last word with no idle cycle.
- load asserted while SEND at word_idx=3 -> load_ready=0; the buffer is unchanged; the remaining words 4..7 come from the original block.
- Assert n_rst low at word_idx=5 -> out_valid=0 and word_idx=0 asynchronously; no done pulse; the next load restarts cleanly at word 0.
- With PTS_SR_ABORT_EN defined: abort at word_idx=2 -> IDLE next cycle, out_valid=0, no done pulse, load_ready=1.
